// File: rtl/timer_entry_register.sv
// Keypad three-digit entry, validation and load/run sequencing for the microwave BCD timer.
// Optional build macro TIMER_ENTRY_CLAMP_EN rejects start when the tens-of-seconds digit exceeds 5.
module timer_entry_register #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] minutes,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       load_n,
  output logic       run,
  output logic [1:0] digit_count,
  output logic       err
);

  localparam logic [1:0] MAX_COUNT = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  state_t     state_reg, state_next;
  // Index 0 is minutes, MAX_DIGITS-1 is units; new keys enter at the units end.
  logic [3:0] digit_reg  [MAX_DIGITS];
  logic [3:0] digit_next [MAX_DIGITS];
  logic [1:0] count_reg, count_next;
  logic       load_n_reg, load_n_next;
  logic       run_reg, run_next;
  logic       err_reg, err_next;

  logic entering;
  logic value_zero;
  logic start_ok;
  logic key_ok;
  logic do_start;
  logic do_key;
  logic shift;
  logic clear_digits;

  assign entering = (state_reg == IDLE) || (state_reg == ENTRY);

  // Event decode: cancel wins outright; a start in an entry state masks any key.
  always_comb begin
    value_zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) && (digit_reg[2] == 4'd0);
    start_ok   = (state_reg == ENTRY) && !value_zero;
`ifdef TIMER_ENTRY_CLAMP_EN
    start_ok   = start_ok && (digit_reg[1] <= 4'd5);
`endif
    key_ok       = (key_digit <= 4'd9) && (count_reg < MAX_COUNT);
    do_start     = !cancel && entering && start;
    do_key       = !cancel && entering && !start && key_valid;
    shift        = do_key && key_ok;
    clear_digits = cancel || ((state_reg == RUN) && timer_zero);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg  <= IDLE;
      count_reg  <= 2'd0;
      load_n_reg <= 1'b1;
      run_reg    <= 1'b0;
      err_reg    <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) digit_reg[i] <= 4'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      load_n_reg <= load_n_next;
      run_reg    <= run_next;
      err_reg    <= err_next;
      for (int i = 0; i < MAX_DIGITS; i++) digit_reg[i] <= digit_next[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cancel) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, ENTRY: begin
          if (do_start) begin
            if (start_ok) state_next = LOAD;
          end else if (shift) begin
            state_next = ENTRY;
          end
        end
        LOAD:    state_next = RUN;
        RUN:     if (timer_zero) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    load_n_next = (state_next != LOAD);
    run_next    = (state_next == RUN);
    err_next    = (do_start && !start_ok) || (do_key && !key_ok);
    count_next  = count_reg;
    if (clear_digits)
      count_next = 2'd0;
    else if (shift)
      count_next = count_reg + 2'd1;
  end

  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
    logic [3:0] shift_in;
    if (gi == MAX_DIGITS - 1) begin : g_last
      assign shift_in = key_digit;
    end else begin : g_inner
      assign shift_in = digit_reg[gi+1];
    end
    assign digit_next[gi] = clear_digits ? 4'd0 : (shift ? shift_in : digit_reg[gi]);
  end

  assign minutes     = digit_reg[0];
  assign tens        = digit_reg[1];
  assign units       = digit_reg[2];
  assign digit_count = count_reg;
  assign load_n      = load_n_reg;
  assign run         = run_reg;
  assign err         = err_reg;

endmodule
